// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_arbiter_pkg : shared widths, memory codes and owner encoding. Rev 1.0
// ---------------------------------------------------------------------------
package mem_arbiter_pkg;

  localparam int ADDR_W      = 32;
  localparam int WORD_W      = 32;
  localparam int MEM_COUNT_W = 2;
  localparam int MEM_CODE_W  = 3;

  localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_NONE = 2'd0;
  localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_BYTE = 2'd1;
  localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_HALF = 2'd2;
  localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_WORD = 2'd3;

  localparam logic [MEM_CODE_W-1:0] MEM_CODE_NONE         = 3'd0;
  localparam logic [MEM_CODE_W-1:0] MEM_CODE_READ         = 3'd1;
  localparam logic [MEM_CODE_W-1:0] MEM_CODE_WRITE        = 3'd2;
  localparam logic [MEM_CODE_W-1:0] MEM_CODE_MISALIGNED   = 3'd3;
  localparam logic [MEM_CODE_W-1:0] MEM_CODE_OUT_OF_RANGE = 3'd4;

  localparam int ARB_OWNER_W = 2;
  localparam logic [ARB_OWNER_W-1:0] ARB_OWNER_NONE = 2'd0;
  localparam logic [ARB_OWNER_W-1:0] ARB_OWNER_IF   = 2'd1;
  localparam logic [ARB_OWNER_W-1:0] ARB_OWNER_DM   = 2'd2;

  typedef logic [ADDR_W-1:0]      addr_t;
  typedef logic [WORD_W-1:0]      word_t;
  typedef logic [MEM_COUNT_W-1:0] mem_count_t;
  typedef logic [MEM_CODE_W-1:0]  mem_code_t;

  // A data request with count NONE is not a request at all.
  function automatic logic dm_req_active(input logic valid, input mem_count_t count);
    return valid && (count != MEM_COUNT_NONE);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_arbiter_if : IF/DM requester and memory-side bus of the arbiter. Rev 1.0
// ---------------------------------------------------------------------------
interface mem_arbiter_if;
  import mem_arbiter_pkg::*;

  logic       i_if_req_valid;
  addr_t      i_if_req_addr;
  logic       o_if_req_ready;
  logic       o_if_res_valid;
  word_t      o_if_res_data;
  mem_code_t  o_if_res_code;

  logic       i_dm_req_valid;
  addr_t      i_dm_req_addr;
  word_t      i_dm_req_wr_data;
  mem_count_t i_dm_req_count;
  logic       i_dm_req_wr_en;
  logic       o_dm_req_ready;
  logic       o_dm_res_valid;
  word_t      o_dm_res_data;
  mem_code_t  o_dm_res_code;

  addr_t      o_mem_req_addr;
  word_t      o_mem_req_wr_data;
  mem_count_t o_mem_req_count;
  logic       o_mem_req_wr_en;
  word_t      i_mem_res_rd_data;
  mem_code_t  i_mem_res_code;

  modport slave (
    input  i_if_req_valid, i_if_req_addr,
    output o_if_req_ready, o_if_res_valid, o_if_res_data, o_if_res_code,
    input  i_dm_req_valid, i_dm_req_addr, i_dm_req_wr_data, i_dm_req_count, i_dm_req_wr_en,
    output o_dm_req_ready, o_dm_res_valid, o_dm_res_data, o_dm_res_code,
    output o_mem_req_addr, o_mem_req_wr_data, o_mem_req_count, o_mem_req_wr_en,
    input  i_mem_res_rd_data, i_mem_res_code
  );

  modport master (
    output i_if_req_valid, i_if_req_addr,
    input  o_if_req_ready, o_if_res_valid, o_if_res_data, o_if_res_code,
    output i_dm_req_valid, i_dm_req_addr, i_dm_req_wr_data, i_dm_req_count, i_dm_req_wr_en,
    input  o_dm_req_ready, o_dm_res_valid, o_dm_res_data, o_dm_res_code,
    input  o_mem_req_addr, o_mem_req_wr_data, o_mem_req_count, o_mem_req_wr_en,
    output i_mem_res_rd_data, i_mem_res_code
  );

endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_arbiter : DM-over-IF memory arbiter with bounded DM streak. Rev 1.0
// ---------------------------------------------------------------------------
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int MAX_DM_STREAK = 4,
  parameter int STREAK_W      = 4
) (
  input  logic         clk,
  input  logic         aresetn,
  mem_arbiter_if.slave bus
);

  localparam logic [STREAK_W-1:0] c_max_streak = STREAK_W'(MAX_DM_STREAK);

  logic [ARB_OWNER_W-1:0] r_owner;
  logic [STREAK_W-1:0]    r_streak;

  logic                   w_if_v;
  logic                   w_dm_v;
  logic                   w_grant_if;
  logic                   w_grant_dm;
  logic [ARB_OWNER_W-1:0] w_owner_nxt;
  logic [STREAK_W-1:0]    w_streak_nxt;

  assign w_if_v = bus.i_if_req_valid;
  assign w_dm_v = dm_req_active(bus.i_dm_req_valid, bus.i_dm_req_count);

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      r_owner  <= ARB_OWNER_NONE;
      r_streak <= '0;
    end else begin
      r_owner  <= w_owner_nxt;
      r_streak <= w_streak_nxt;
    end
  end

  // The streak only grows while IF is left waiting; any other cycle clears it.
  always_comb begin
    w_grant_if   = 1'b0;
    w_grant_dm   = 1'b0;
    w_owner_nxt  = ARB_OWNER_NONE;
    w_streak_nxt = '0;
    if (aresetn) begin
      if (w_if_v && (!w_dm_v || (r_streak == c_max_streak))) begin
        w_grant_if  = 1'b1;
        w_owner_nxt = ARB_OWNER_IF;
      end else if (w_dm_v) begin
        w_grant_dm  = 1'b1;
        w_owner_nxt = ARB_OWNER_DM;
        if (w_if_v) begin
          w_streak_nxt = (r_streak == c_max_streak) ? r_streak : r_streak + 1'b1;
        end
      end
    end
  end

  always_comb begin
    bus.o_if_req_ready    = w_grant_if;
    bus.o_dm_req_ready    = w_grant_dm;
    bus.o_mem_req_addr    = '0;
    bus.o_mem_req_wr_data = '0;
    bus.o_mem_req_count   = MEM_COUNT_NONE;
    bus.o_mem_req_wr_en   = 1'b0;
    if (w_grant_if) begin
      bus.o_mem_req_addr  = bus.i_if_req_addr;
      bus.o_mem_req_count = MEM_COUNT_WORD;
    end else if (w_grant_dm) begin
      bus.o_mem_req_addr    = bus.i_dm_req_addr;
      bus.o_mem_req_wr_data = bus.i_dm_req_wr_data;
      bus.o_mem_req_count   = bus.i_dm_req_count;
      bus.o_mem_req_wr_en   = bus.i_dm_req_wr_en;
    end

    // Gating with aresetn drops a response that is in flight when reset hits.
    bus.o_if_res_valid = aresetn && (r_owner == ARB_OWNER_IF);
    bus.o_dm_res_valid = aresetn && (r_owner == ARB_OWNER_DM);
    bus.o_if_res_data  = bus.o_if_res_valid ? bus.i_mem_res_rd_data : '0;
    bus.o_if_res_code  = bus.o_if_res_valid ? bus.i_mem_res_code    : MEM_CODE_NONE;
    bus.o_dm_res_data  = bus.o_dm_res_valid ? bus.i_mem_res_rd_data : '0;
    bus.o_dm_res_code  = bus.o_dm_res_valid ? bus.i_mem_res_code    : MEM_CODE_NONE;
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mem_arbiter : randomized scoreboard bench with a behavioural memory. Rev 1.0
// ---------------------------------------------------------------------------
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int MAXS       = 4;
  localparam int WORD_COUNT = 128;
  localparam int MEM_BYTES  = WORD_COUNT * 4;

  typedef struct packed {
    logic      ifv;
    logic      dmv;
    word_t     data;
    mem_code_t code;
  } resp_t;

  logic clk = 1'b0;
  logic aresetn;
  always #5 clk = ~clk;

  mem_arbiter_if bus();

  mem_arbiter #(.MAX_DM_STREAK(MAXS), .STREAK_W(4)) dut (
    .clk     (clk),
    .aresetn (aresetn),
    .bus     (bus)
  );

  logic [7:0] env_mem [MEM_BYTES] = '{default: 8'h00};
  logic [7:0] ref_mem [MEM_BYTES] = '{default: 8'h00};

  resp_t exp_q[$];
  int    vectors     = 0;
  int    miscompares = 0;
  int    if_waited_dm_run = 0;

  // Little-endian byte memory with WORD_COUNT words; use_ref picks the model copy.
  function automatic void mem_access(input bit use_ref, input addr_t a, input word_t wd,
                                     input mem_count_t cnt, input logic we,
                                     output word_t rd, output mem_code_t code);
    int n;
    rd = '0;
    n  = (cnt == MEM_COUNT_BYTE) ? 1 : (cnt == MEM_COUNT_HALF) ? 2 :
         (cnt == MEM_COUNT_WORD) ? 4 : 0;
    if (n == 0) begin
      code = MEM_CODE_NONE;
    end else if ((a % n) != 0) begin
      code = MEM_CODE_MISALIGNED;
    end else if (a + n > MEM_BYTES) begin
      code = MEM_CODE_OUT_OF_RANGE;
    end else begin
      code = we ? MEM_CODE_WRITE : MEM_CODE_READ;
      for (int k = 0; k < n; k++) begin
        if (we) begin
          if (use_ref) ref_mem[a + k] = wd[8*k +: 8];
          else         env_mem[a + k] = wd[8*k +: 8];
        end else begin
          rd[8*k +: 8] = use_ref ? ref_mem[a + k] : env_mem[a + k];
        end
      end
    end
  endfunction

  always @(posedge clk) begin : env_memory
    word_t     rd;
    mem_code_t cd;
    mem_access(1'b0, bus.o_mem_req_addr, bus.o_mem_req_wr_data, bus.o_mem_req_count,
               bus.o_mem_req_wr_en, rd, cd);
    bus.i_mem_res_rd_data <= rd;
    bus.i_mem_res_code    <= cd;
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // One bus cycle: drive, check the combinational request side, queue the response.
  task automatic step(input logic rstn, input logic ifv, input addr_t ifa,
                      input logic dmv, input addr_t dma, input word_t dmd,
                      input mem_count_t dmc, input logic dmw);
    logic      gi, gd, dm_real;
    addr_t     ea;
    word_t     ed, rd;
    mem_count_t ec;
    logic      ew;
    mem_code_t cd;
    resp_t     r;
    @(posedge clk);
    #2;
    aresetn              = rstn;
    bus.i_if_req_valid   = ifv;
    bus.i_if_req_addr    = ifa;
    bus.i_dm_req_valid   = dmv;
    bus.i_dm_req_addr    = dma;
    bus.i_dm_req_wr_data = dmd;
    bus.i_dm_req_count   = dmc;
    bus.i_dm_req_wr_en   = dmw;
    #2;
    dm_real = dmv && (dmc != MEM_COUNT_NONE);
    gi = 1'b0;
    gd = 1'b0;
    if (rstn) begin
      if (ifv && dm_real) begin
        if (if_waited_dm_run >= MAXS) gi = 1'b1;
        else                          gd = 1'b1;
      end else begin
        gi = ifv;
        gd = dm_real;
      end
    end
    if (rstn && ifv && gd) if_waited_dm_run++;
    else                   if_waited_dm_run = 0;

    ea = '0; ed = '0; ec = MEM_COUNT_NONE; ew = 1'b0;
    r  = '0;
    if (gi) begin
      ea = ifa; ec = MEM_COUNT_WORD;
      mem_access(1'b1, ifa, '0, MEM_COUNT_WORD, 1'b0, rd, cd);
      r = '{ifv: 1'b1, dmv: 1'b0, data: rd, code: cd};
    end else if (gd) begin
      ea = dma; ed = dmd; ec = dmc; ew = dmw;
      mem_access(1'b1, dma, dmd, dmc, dmw, rd, cd);
      r = '{ifv: 1'b0, dmv: 1'b1, data: rd, code: cd};
    end
    check("ready", {bus.o_if_req_ready, bus.o_dm_req_ready}, {gi, gd});
    check("mem_req", {bus.o_mem_req_addr, bus.o_mem_req_wr_data, bus.o_mem_req_count,
                      bus.o_mem_req_wr_en}, {ea, ed, ec, ew});
    if (!rstn) check("res_in_reset", {bus.o_if_res_valid, bus.o_dm_res_valid}, 2'b00);
    exp_q.push_back(r);
  endtask

  task automatic idle();
    step(1'b1, 1'b0, '0, 1'b0, '0, '0, MEM_COUNT_NONE, 1'b0);
  endtask

  initial begin : monitor
    resp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("res_valid", {bus.o_if_res_valid, bus.o_dm_res_valid}, {e.ifv, e.dmv});
        check("if_res", {bus.o_if_res_data, bus.o_if_res_code},
              e.ifv ? {e.data, e.code} : '0);
        check("dm_res", {bus.o_dm_res_data, bus.o_dm_res_code},
              e.dmv ? {e.data, e.code} : '0);
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish required finish");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    addr_t      a;
    mem_count_t c;
    logic       iv, dv, rs;
    aresetn              = 1'b0;
    bus.i_if_req_valid   = 1'b0;
    bus.i_if_req_addr    = '0;
    bus.i_dm_req_valid   = 1'b0;
    bus.i_dm_req_addr    = '0;
    bus.i_dm_req_wr_data = '0;
    bus.i_dm_req_count   = MEM_COUNT_NONE;
    bus.i_dm_req_wr_en   = 1'b0;

    // Reset held with both requesters active, then both still active on release.
    for (int i = 0; i < 5; i++)
      step(1'b0, 1'b1, 32'h0, 1'b1, 32'h4, 32'h0, MEM_COUNT_WORD, 1'b0);
    step(1'b1, 1'b1, 32'h0, 1'b1, 32'h4, 32'h0, MEM_COUNT_WORD, 1'b0);
    idle();

    // Store then fetch the same word.
    step(1'b1, 1'b0, '0, 1'b1, 32'h10, 32'h12345678, MEM_COUNT_WORD, 1'b1);
    step(1'b1, 1'b1, 32'h10, 1'b0, '0, '0, MEM_COUNT_NONE, 1'b0);
    idle();

    // Contention on the same address: store wins, fetch sees the new data.
    step(1'b1, 1'b1, 32'h20, 1'b1, 32'h20, 32'hdeadbeef, MEM_COUNT_WORD, 1'b1);
    step(1'b1, 1'b1, 32'h20, 1'b0, '0, '0, MEM_COUNT_NONE, 1'b0);
    idle();

    // Continuous contention exposes the streak limit.
    for (int i = 0; i < 10; i++)
      step(1'b1, 1'b1, 32'h40, 1'b1, addr_t'(4 * i), '0, MEM_COUNT_WORD, 1'b0);
    idle();

    // Misaligned store, then an ordinary fetch.
    step(1'b1, 1'b0, '0, 1'b1, 32'h1, 32'hcafef00d, MEM_COUNT_WORD, 1'b1);
    step(1'b1, 1'b1, 32'h0, 1'b0, '0, '0, MEM_COUNT_NONE, 1'b0);

    // DM request with count NONE is ignored.
    step(1'b1, 1'b0, '0, 1'b1, 32'h8, 32'h1, MEM_COUNT_NONE, 1'b1);
    idle();

    // Build up a streak, fetch, then reset while the fetch response is out.
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b1, 32'h80, 1'b1, 32'h30, '0, MEM_COUNT_HALF, 1'b0);
    step(1'b1, 1'b1, 32'h80, 1'b0, '0, '0, MEM_COUNT_NONE, 1'b0);
    step(1'b0, 1'b1, 32'h80, 1'b1, 32'h30, '0, MEM_COUNT_WORD, 1'b0);
    for (int i = 0; i < 6; i++)
      step(1'b1, 1'b1, 32'h84, 1'b1, 32'h34, '0, MEM_COUNT_BYTE, 1'b0);
    idle();

    // Randomized traffic, biased towards contention and aligned accesses.
    for (int i = 0; i < 400; i++) begin
      iv = ($urandom_range(0, 3) != 0);
      dv = ($urandom_range(0, 3) != 0);
      rs = ($urandom_range(0, 99) != 0);
      c  = mem_count_t'($urandom_range(0, 3));
      a  = addr_t'($urandom_range(0, WORD_COUNT - 1) * 4);
      if ($urandom_range(0, 4) == 0) a = a + addr_t'($urandom_range(1, 3));
      step(rs, iv, addr_t'($urandom_range(0, WORD_COUNT - 1) * 4), dv, a,
           word_t'($urandom), c, 1'($urandom_range(0, 1)));
    end
    idle();

    @(posedge clk);
    #2;
    check("queue_drain", 128'(exp_q.size()), 128'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
